// File: rtl/vga_timing_gen_if.sv
// Pixel-stream interface between the timing generator (master) and the
// downstream overlay stages (slave). The slave side owns the pixel enable.
interface vga_timing_gen_if;
    logic        pix_en;
    logic [9:0]  hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        blnk_out;
    logic        frame_start;
    logic [23:0] rgb_out;

    modport master (
        input  pix_en,
        output hcount_out, vcount_out, hsync_out, vsync_out,
        output blnk_out, frame_start, rgb_out
    );

    modport slave (
        output pix_en,
        input  hcount_out, vcount_out, hsync_out, vsync_out,
        input  blnk_out, frame_start, rgb_out
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator, 640x480@60 (800x525 total) by default.
// Produces position, syncs, blanking and a frame-start pulse, all registered
// together so they stay aligned. Define VGA_TEST_PATTERN_EN to drive eight
// vertical colour bars on rgb_out; otherwise rgb_out is tied to zero.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_q, v_q;
    logic       hs_q, vs_q, bl_q, fs_q;
    logic [9:0] h_nx, v_nx;
    logic       hs_nx, vs_nx, bl_nx, fs_nx;

    // Next position and its decode, so every output is registered in one step
    always_comb begin
        h_nx = h_q + 10'd1;
        v_nx = v_q;
        if (h_q == H_LAST) begin
            h_nx = '0;
            v_nx = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        bl_nx = (h_nx >= H_ACT) || (v_nx >= V_ACT);
        hs_nx = ((h_nx >= HS_BEG) && (h_nx < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_nx = ((v_nx >= VS_BEG) && (v_nx < VS_END)) ? SYNC_POL : ~SYNC_POL;
        fs_nx = (h_nx == '0) && (v_nx == '0);
    end

    // Position/decode registers; advance only on pixel enable, pulse cleared otherwise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            bl_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (vga.pix_en) begin
            h_q  <= h_nx;
            v_q  <= v_nx;
            hs_q <= hs_nx;
            vs_q <= vs_nx;
            bl_q <= bl_nx;
            fs_q <= fs_nx;
        end else begin
            fs_q <= 1'b0;
        end
    end

    assign vga.hcount_out  = h_q;
    assign vga.vcount_out  = v_q;
    assign vga.hsync_out   = hs_q;
    assign vga.vsync_out   = vs_q;
    assign vga.blnk_out    = bl_q;
    assign vga.frame_start = fs_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

    function automatic logic [23:0] bar_rgb(input logic [9:0] h);
        logic [9:0] idx;
        idx = h / BAR_W;
        case (idx)
            10'd0:   return 24'hff_ff_ff;
            10'd1:   return 24'hff_ff_00;
            10'd2:   return 24'h00_ff_ff;
            10'd3:   return 24'h00_ff_00;
            10'd4:   return 24'hff_00_ff;
            10'd5:   return 24'hff_00_00;
            10'd6:   return 24'h00_00_ff;
            default: return 24'h00_00_00;
        endcase
    endfunction

    logic [23:0] rgb_q;

    // Colour bars registered with the position so they carry no skew
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_q <= bar_rgb(10'd0);
        end else if (vga.pix_en) begin
            rgb_q <= bl_nx ? '0 : bar_rgb(h_nx);
        end
    end

    assign vga.rgb_out = rgb_q;
`else
    assign vga.rgb_out = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-size instance for line-level
// checks and a shrunken, active-high-sync instance for frame-level corners.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if big_if ();
    vga_timing_gen_if small_if ();

    vga_timing_gen u_big (
        .clk (clk),
        .rst (rst),
        .vga (big_if)
    );

    // Small frame: H_TOTAL=24 (hsync 18..21), V_TOTAL=19 (vsync 14..15), 456 px/frame
    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
        .V_ACTIVE (12), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .SYNC_POL (1'b1)
    ) u_small (
        .clk (clk),
        .rst (rst),
        .vga (small_if)
    );

    typedef struct {
        int unsigned cycles;
        logic        en;
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic [23:0] rgb;
    } vec_t;

    function automatic vec_t mk(input int unsigned c, input logic en, input int h, input int v,
                                input logic hs, input logic vs, input logic bl, input logic fs,
                                input logic [23:0] rgb);
        vec_t r;
        r.cycles = c; r.en = en; r.h = 10'(h); r.v = 10'(v);
        r.hs = hs; r.vs = vs; r.bl = bl; r.fs = fs; r.rgb = rgb;
        return r;
    endfunction

    function automatic logic [23:0] exp_rgb(input logic [23:0] pat);
`ifdef VGA_TEST_PATTERN_EN
        return pat;
`else
        return pat & 24'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_big(input string t, input logic [9:0] h, input logic [9:0] v,
                           input logic hs, input logic vs, input logic bl, input logic fs,
                           input logic [23:0] rgb);
        chk({t, ".h"},   32'(big_if.hcount_out),  32'(h));
        chk({t, ".v"},   32'(big_if.vcount_out),  32'(v));
        chk({t, ".hs"},  32'(big_if.hsync_out),   32'(hs));
        chk({t, ".vs"},  32'(big_if.vsync_out),   32'(vs));
        chk({t, ".bl"},  32'(big_if.blnk_out),    32'(bl));
        chk({t, ".fs"},  32'(big_if.frame_start), 32'(fs));
        chk({t, ".rgb"}, 32'(big_if.rgb_out),     32'(exp_rgb(rgb)));
    endtask

    task automatic chk_small(input string t, input int h, input int v,
                             input logic hs, input logic vs, input logic bl, input logic fs);
        chk({t, ".h"},  32'(small_if.hcount_out),  32'(h));
        chk({t, ".v"},  32'(small_if.vcount_out),  32'(v));
        chk({t, ".hs"}, 32'(small_if.hsync_out),   32'(hs));
        chk({t, ".vs"}, 32'(small_if.vsync_out),   32'(vs));
        chk({t, ".bl"}, 32'(small_if.blnk_out),    32'(bl));
        chk({t, ".fs"}, 32'(small_if.frame_start), 32'(fs));
    endtask

    // n active edges, then settle at the following falling edge
    task automatic adv(input int unsigned n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tbl[16];
    int   cnt;

    initial begin
        tbl[0]  = mk(1,    1'b1, 1,   0,  1'b1, 1'b1, 1'b0, 1'b0, 24'hffffff);
        tbl[1]  = mk(79,   1'b1, 80,  0,  1'b1, 1'b1, 1'b0, 1'b0, 24'hffff00);
        tbl[2]  = mk(559,  1'b1, 639, 0,  1'b1, 1'b1, 1'b0, 1'b0, 24'h000000);
        tbl[3]  = mk(1,    1'b1, 640, 0,  1'b1, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[4]  = mk(15,   1'b1, 655, 0,  1'b1, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[5]  = mk(1,    1'b1, 656, 0,  1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[6]  = mk(44,   1'b1, 700, 0,  1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[7]  = mk(51,   1'b1, 751, 0,  1'b0, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[8]  = mk(1,    1'b1, 752, 0,  1'b1, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[9]  = mk(47,   1'b1, 799, 0,  1'b1, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[10] = mk(1,    1'b1, 0,   1,  1'b1, 1'b1, 1'b0, 1'b0, 24'hffffff);
        tbl[11] = mk(7999, 1'b1, 799, 10, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000);
        tbl[12] = mk(1,    1'b1, 0,   11, 1'b1, 1'b1, 1'b0, 1'b0, 24'hffffff);
        tbl[13] = mk(300,  1'b1, 300, 11, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00ff00);
        tbl[14] = mk(5,    1'b0, 300, 11, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00ff00);
        tbl[15] = mk(1,    1'b1, 301, 11, 1'b1, 1'b1, 1'b0, 1'b0, 24'h00ff00);

        big_if.pix_en   = 1'b1;
        small_if.pix_en = 1'b0;
        rst = 1'b0;
        adv(3);
        chk_big("reset", 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hffffff);
        rst = 1'b1;

        for (int unsigned i = 0; i < 16; i++) begin
            big_if.pix_en = tbl[i].en;
            adv(tbl[i].cycles);
            chk_big($sformatf("row%0d", i), tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs,
                    tbl[i].bl, tbl[i].fs, tbl[i].rgb);
        end

        // Asynchronous reset mid-line, sampled before the next rising edge
        #2 rst = 1'b0;
        #1 chk_big("arst", 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hffffff);
        @(negedge clk);
        rst = 1'b1;
        adv(1);
        chk_big("post_rst", 10'd1, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 24'hffffff);
        big_if.pix_en = 1'b0;

        // Frame-level corners on the small instance (syncs active-high)
        chk_small("s_idle", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        small_if.pix_en = 1'b1;
        adv(335);
        chk_small("s_23_13", 23, 13, 1'b0, 1'b0, 1'b1, 1'b0);
        adv(1);
        chk_small("s_0_14", 0, 14, 1'b0, 1'b1, 1'b1, 1'b0);
        adv(19);
        chk_small("s_19_14", 19, 14, 1'b1, 1'b1, 1'b1, 1'b0);
        adv(28);
        chk_small("s_23_15", 23, 15, 1'b0, 1'b1, 1'b1, 1'b0);
        adv(1);
        chk_small("s_0_16", 0, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        adv(71);
        chk_small("s_23_18", 23, 18, 1'b0, 1'b0, 1'b1, 1'b0);
        adv(1);
        chk_small("s_wrap", 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        cnt = 0;
        do begin
            adv(1);
            cnt++;
        end while (small_if.frame_start !== 1'b1 && cnt < 1000);
        chk("s_fs_spacing", 32'(cnt), 32'd456);

        small_if.pix_en = 1'b0;
        adv(1);
        chk_small("s_fs_gated", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
